ripple_count_sampler: RTL and testbench
=======================================

Name: ripple_count_sampler

Overview:
- Downstream consumer of the 4-bit asynchronous ripple counter's q outputs.
- Brings the ripple count into the system clk domain and filters the transient intermediate codes the ripple chain produces while it settles.
- Extends the count with wrap tracking, flags illegal jumps and compares the result against a programmable threshold.
- Output feeds control logic that cannot tolerate the ripple counter's skewed bit transitions.

Parameters:
- WIDTH, 4, width of the ripple count input.
- EXT_WIDTH, 8, width of the wrap-extension field.
- STABLE_CYCLES, 2, number of consecutive identical synchronized samples required before a value is accepted (legal range 1..7).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- count_in  input  WIDTH  ripple counter q outputs; asynchronous to clk.
- threshold  input  WIDTH+EXT_WIDTH  compare value for match; quasi-static.
- clear  input  1  synchronous clear of the extension field and the error flag.
- count_out  output  WIDTH+EXT_WIDTH  {ext, last_accepted}.
- count_valid  output  1  one-cycle pulse when count_out updates.
- wrap  output  1  one-cycle pulse, coincident with count_valid, when a wrap is detected.
- match  output  1  level; count_out >= threshold, registered.
- error  output  1  sticky; an accepted value was not last_accepted+1 mod 2^WIDTH.

Behaviour:
- Reset (clk edge with reset=1) clears all state to 0:
  - sync1, sync2, candidate, stable counter, last_accepted, ext, primed flag;
  - all outputs: count_out=0, count_valid=0, wrap=0, match=0, error=0.
- Reset asserted mid-operation: every output is 0 on the following cycle, regardless of pending accepts.
- Synchronizer: two flops per bit, count_in -> sync1 -> sync2.
- Stability filter:
  - stab_cnt resets to 1 whenever sync2 != candidate, and candidate <= sync2 on that edge.
  - Otherwise stab_cnt increments, saturating at STABLE_CYCLES.
  - A value is "stable" when stab_cnt == STABLE_CYCLES.
- Accept: when the value is stable and candidate != last_accepted, or when it is stable and primed==0. Exactly one accept per distinct stable value.
- First accept after reset (primed==0):
  - last_accepted <= candidate; primed <= 1; count_valid pulses.
  - No wrap pulse, no ext change, no error, even if the value is nonzero (the ripple counter has its own reset).
- Subsequent accepts:
  - last_accepted <= candidate; count_valid pulses.
  - If candidate < old last_accepted: ext <= ext+1 and wrap pulses.
  - If candidate != old last_accepted+1 mod 2^WIDTH: error <= 1.
- A 15->0 transition (WIDTH=4) is a legal wrap: wrap=1, error unchanged.
- ext wraps from 2^EXT_WIDTH-1 to 0 silently; wrap still pulses.
- Latency: count_valid and the new count_out appear on the clock edge STABLE_CYCLES+2 edges after the first edge at which count_in is settled at the new value. An input that changes again before then is never accepted.
- count_valid and wrap are registered, one cycle wide, and both low otherwise.
- match <= (count_out >= threshold), registered.
  - Reflects the count_out of the previous cycle, so it lags count_valid by one cycle.
  - The comparison is unsigned.
- error stays set until clear or reset.
- clear=1:
  - ext <= 0 and error <= 0; last_accepted and primed are unchanged.
  - If an accept occurs in the same cycle: clear wins on ext (result 0, no increment) and on error (result 0). last_accepted still updates, and count_valid and wrap still pulse as computed.
- threshold or clear changes affect match one cycle after count_out reflects them.

Test Plan:
- Reset, then count_in=0 held: first count_valid on edge 4 (STABLE_CYCLES=2) with count_out=0x000, wrap=0, error=0; no further pulses while count_in holds.
- Step count_in 0,1,...,15,0,1 with each value held 6 cycles: 17 count_valid pulses after the first; wrap pulses only on 15->0; count_out ends at 0x011; error=0.
- Glitch: from 0x3 drive 0x2 for 1 cycle, then 0x4 (ripple transient 3->2->4): no accept of 0x2; single accept of 0x4, count_out=0x004, error=0.
- Jump: accepted 0x5, then hold 0x9: count_out=0x009, error=1 and sticky; pulse clear while 0x9 holds: error=0, count_out=0x009.
- Threshold=0x012, count 15->0->1->2 after one prior wrap: match rises exactly one cycle after count_out becomes 0x012; clear coincident with a 15->0 accept yields count_out=0x000 with wrap=1.
- Reset asserted mid-sequence with count_in=0x7: all outputs 0 next cycle; after release the first accept gives count_out=0x007 with error=0 and wrap=0.

Source files
------------

// File: rtl/ripple_count_sampler.sv
// Samples an asynchronous ripple-counter output into the clk domain. It accepts only settled codes,
// extends the count across wraps, flags illegal jumps and compares the result against a threshold.
module ripple_count_sampler #(
    parameter int WIDTH         = 4,
    parameter int EXT_WIDTH     = 8,
    parameter int STABLE_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           count_in,
    input  logic [WIDTH+EXT_WIDTH-1:0] threshold,
    input  logic                       clear,
    output logic [WIDTH+EXT_WIDTH-1:0] count_out,
    output logic                       count_valid,
    output logic                       wrap,
    output logic                       match,
    output logic                       error
);

    localparam logic [2:0] STAB_MAX = 3'(STABLE_CYCLES);

    logic [WIDTH-1:0]     sync1_r;
    logic [WIDTH-1:0]     sync2_r;
    logic [WIDTH-1:0]     candidate_r;
    logic [2:0]           stab_cnt_r;
    logic [WIDTH-1:0]     last_r;
    logic [EXT_WIDTH-1:0] ext_r;
    logic                 primed_r;
    logic                 count_valid_r;
    logic                 wrap_r;
    logic                 match_r;
    logic                 error_r;

    logic                 stable_s;
    logic                 accept_s;
    logic                 wrap_s;
    logic                 jump_s;
    logic [EXT_WIDTH-1:0] ext_nxt_s;
    logic                 error_nxt_s;

    function automatic logic [WIDTH-1:0] next_code(input logic [WIDTH-1:0] code);
        return code + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Accept decision and the resulting extension and error updates
    always_comb begin
        stable_s    = 1'b0;
        accept_s    = 1'b0;
        wrap_s      = 1'b0;
        jump_s      = 1'b0;
        ext_nxt_s   = ext_r;
        error_nxt_s = error_r;
        // sync2 must still agree with the candidate, so a code that moves on as it matures is rejected
        stable_s = (stab_cnt_r == STAB_MAX) && (sync2_r == candidate_r);
        accept_s = stable_s && (!primed_r || (candidate_r != last_r));
        if (accept_s && primed_r) begin
            wrap_s = (candidate_r < last_r);
            jump_s = (candidate_r != next_code(last_r));
        end else begin
            wrap_s = 1'b0;
            jump_s = 1'b0;
        end
        if (clear) begin
            ext_nxt_s   = {EXT_WIDTH{1'b0}};
            error_nxt_s = 1'b0;
        end else if (wrap_s) begin
            ext_nxt_s   = ext_r + {{(EXT_WIDTH-1){1'b0}}, 1'b1};
            error_nxt_s = error_r | jump_s;
        end else begin
            ext_nxt_s   = ext_r;
            error_nxt_s = error_r | jump_s;
        end
    end

    // Synchronizer, stability filter, accepted state and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r       <= {WIDTH{1'b0}};
            sync2_r       <= {WIDTH{1'b0}};
            candidate_r   <= {WIDTH{1'b0}};
            stab_cnt_r    <= 3'd0;
            last_r        <= {WIDTH{1'b0}};
            ext_r         <= {EXT_WIDTH{1'b0}};
            primed_r      <= 1'b0;
            count_valid_r <= 1'b0;
            wrap_r        <= 1'b0;
            match_r       <= 1'b0;
            error_r       <= 1'b0;
        end else begin
            sync1_r <= count_in;
            sync2_r <= sync1_r;
            if (sync2_r != candidate_r) begin
                candidate_r <= sync2_r;
                stab_cnt_r  <= 3'd1;
            end else if (stab_cnt_r != STAB_MAX) begin
                stab_cnt_r  <= stab_cnt_r + 3'd1;
            end else begin
                stab_cnt_r  <= stab_cnt_r;
            end
            if (accept_s) begin
                last_r   <= candidate_r;
                primed_r <= 1'b1;
            end else begin
                last_r   <= last_r;
                primed_r <= primed_r;
            end
            ext_r         <= ext_nxt_s;
            error_r       <= error_nxt_s;
            count_valid_r <= accept_s;
            wrap_r        <= wrap_s;
            // Compares the count_out currently presented, so match trails count_valid by one cycle
            match_r       <= ({ext_r, last_r} >= threshold);
        end
    end

    assign count_out   = {ext_r, last_r};
    assign count_valid = count_valid_r;
    assign wrap        = wrap_r;
    assign match       = match_r;
    assign error       = error_r;

endmodule

// File: tb/tb_ripple_count_sampler.sv
// Scoreboard bench for ripple_count_sampler: each expected accept is queued when its stimulus is
// driven and is checked against the DUT when count_valid pulses.
module tb_ripple_count_sampler;

    logic        clk;
    logic        reset;
    logic [3:0]  count_in;
    logic [11:0] threshold;
    logic        clear;
    logic [11:0] count_out;
    logic        count_valid;
    logic        wrap;
    logic        match;
    logic        error;

    typedef struct packed {
        logic [11:0] co;
        logic        w;
        logic        e;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    int   wraps  = 0;
    bit   mon_en = 1'b0;

    logic [3:0] m_last;
    logic [7:0] m_ext;
    logic       m_err;
    logic       m_primed;

    ripple_count_sampler #(.WIDTH(4), .EXT_WIDTH(8), .STABLE_CYCLES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .count_in   (count_in),
        .threshold  (threshold),
        .clear      (clear),
        .count_out  (count_out),
        .count_valid(count_valid),
        .wrap       (wrap),
        .match      (match),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: every count_valid pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (count_valid === 1'b1) begin
                pulses++;
                if (wrap === 1'b1) wraps++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: count_out=%h with no accept expected", count_out);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (count_out !== e.co || wrap !== e.w || error !== e.e) begin
                        errors++;
                        $display("FAIL sb_accept: got count_out=%h wrap=%b error=%b, want count_out=%h wrap=%b error=%b",
                                 count_out, wrap, error, e.co, e.w, e.e);
                    end
                end
            end else if (wrap !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL wrap_alone: got wrap=%b, want 0 without count_valid", wrap);
            end
        end
    end

    task automatic exp_accept(input logic [3:0] v);
        if (!m_primed) begin
            m_primed = 1'b1;
            m_last   = v;
            sb.push_back({m_ext, v, 1'b0, m_err});
        end else if (v != m_last) begin
            logic w;
            w = (v < m_last);
            if (w) m_ext = m_ext + 8'd1;
            if (v != m_last + 4'd1) m_err = 1'b1;
            m_last = v;
            sb.push_back({m_ext, v, w, m_err});
        end
    endtask

    task automatic hold_value(input logic [3:0] v, input int n);
        exp_accept(v);
        count_in = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_reset();
        m_last   = 4'd0;
        m_ext    = 8'd0;
        m_err    = 1'b0;
        m_primed = 1'b0;
        sb.delete();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d accepts outstanding, want 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        int p0;
        count_in = 4'd0;
        apply_reset();
        mon_en = 1'b1;
        p0 = pulses;
        @(negedge clk);
        checks++;
        if ({count_out, count_valid, wrap, match, error} !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h/%b/%b/%b/%b, want all 0", count_out, count_valid, wrap, match, error);
        end
        sb.push_back({12'h000, 1'b0, 1'b0});
        m_primed = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (count_valid !== (k == 3)) begin
                errors++;
                $display("FAIL reset_first_valid: edge %0d got count_valid=%b, want %b", k, count_valid, (k == 3));
            end
        end
        repeat (10) @(negedge clk);
        wait_drain("reset");
        checks++;
        if (pulses - p0 != 1) begin
            errors++;
            $display("FAIL reset_pulses: got %0d pulses, want 1", pulses - p0);
        end
    endtask

    task automatic test_count_sequence();
        int p0, w0;
        count_in = 4'd0;
        apply_reset();
        exp_accept(4'd0);
        repeat (8) @(posedge clk);
        #1;
        wait_drain("seq_first");
        p0 = pulses;
        w0 = wraps;
        for (int i = 1; i <= 17; i++) hold_value(4'(i % 16), 6);
        wait_drain("seq");
        checks++;
        if (pulses - p0 != 17 || wraps - w0 != 1) begin
            errors++;
            $display("FAIL seq_pulses: got valid=%0d wrap=%0d, want valid=17 wrap=1", pulses - p0, wraps - w0);
        end
        @(negedge clk);
        checks++;
        if (count_out !== 12'h011 || error !== 1'b0) begin
            errors++;
            $display("FAIL seq_final: got count_out=%h error=%b, want 011 and 0", count_out, error);
        end
    endtask

    task automatic test_glitch();
        int p0;
        count_in = 4'd3;
        apply_reset();
        hold_value(4'd3, 8);
        wait_drain("glitch_first");
        p0 = pulses;
        count_in = 4'd2;
        @(posedge clk);
        #1;
        hold_value(4'd4, 8);
        wait_drain("glitch");
        @(negedge clk);
        checks++;
        if (pulses - p0 != 1 || count_out !== 12'h004 || error !== 1'b0) begin
            errors++;
            $display("FAIL glitch: got pulses=%0d count_out=%h error=%b, want 1, 004, 0", pulses - p0, count_out, error);
        end
    endtask

    task automatic test_jump();
        count_in = 4'd5;
        apply_reset();
        hold_value(4'd5, 8);
        hold_value(4'd9, 8);
        wait_drain("jump");
        repeat (5) @(negedge clk);
        checks++;
        if (count_out !== 12'h009 || error !== 1'b1) begin
            errors++;
            $display("FAIL jump_sticky: got count_out=%h error=%b, want 009 and 1", count_out, error);
        end
        @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        m_err = 1'b0;
        @(negedge clk);
        checks++;
        if (count_out !== 12'h009 || error !== 1'b0) begin
            errors++;
            $display("FAIL jump_clear: got count_out=%h error=%b, want 009 and 0", count_out, error);
        end
    endtask

    task automatic test_match_clear();
        bit found;
        count_in = 4'd15;
        apply_reset();
        hold_value(4'd15, 8);
        hold_value(4'd0, 6);
        hold_value(4'd1, 6);
        wait_drain("match_pre");
        @(negedge clk);
        checks++;
        if (match !== 1'b0) begin
            errors++;
            $display("FAIL match_below: got match=%b at count_out=%h, want 0", match, count_out);
        end
        exp_accept(4'd2);
        count_in = 4'd2;
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (count_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found || count_out !== 12'h012 || match !== 1'b0) begin
            errors++;
            $display("FAIL match_same_cycle: got found=%b count_out=%h match=%b, want 1, 012, 0", found, count_out, match);
        end
        @(negedge clk);
        checks++;
        if (match !== 1'b1) begin
            errors++;
            $display("FAIL match_rise: got match=%b, want 1", match);
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        hold_value(4'd15, 6);
        // 15->0 accept lands four edges after the change; raise clear for exactly that edge
        m_ext = 8'd0;
        m_err = 1'b0;
        m_last = 4'd0;
        sb.push_back({12'h000, 1'b1, 1'b0});
        count_in = 4'd0;
        repeat (4) @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        wait_drain("clear_wrap");
        repeat (3) @(negedge clk);
        checks++;
        if (count_out !== 12'h000 || error !== 1'b0 || match !== 1'b0) begin
            errors++;
            $display("FAIL clear_wrap_final: got count_out=%h error=%b match=%b, want 000, 0, 0", count_out, error, match);
        end
    endtask

    task automatic test_reset_midop();
        count_in = 4'd6;
        apply_reset();
        hold_value(4'd6, 8);
        hold_value(4'd9, 8);
        wait_drain("midop_pre");
        count_in = 4'd7;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if ({count_out, count_valid, wrap, match, error} !== 16'd0) begin
            errors++;
            $display("FAIL midop_reset: got %h/%b/%b/%b/%b, want all 0", count_out, count_valid, wrap, match, error);
        end
        exp_accept(4'd7);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        wait_drain("midop");
        @(negedge clk);
        checks++;
        if (count_out !== 12'h007 || error !== 1'b0) begin
            errors++;
            $display("FAIL midop_after: got count_out=%h error=%b, want 007 and 0", count_out, error);
        end
    endtask

    initial begin
        reset     = 1'b1;
        clear     = 1'b0;
        count_in  = 4'd0;
        threshold = 12'h012;
        model_reset();
        test_reset();
        test_count_sequence();
        test_glitch();
        test_jump();
        test_match_clear();
        test_reset_midop();
        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
